// File: rtl/cpu_slave_sm.sv
// 68030 register-space slave: synchronises AS_/DS_, strobes the register file once, returns 32-bit DSACK.
// Latency: strobes sampled low at e0 -> REG_RD/REG_WR after e2 -> DSACK low after e4+WAIT_STATES (RACK high).
// Backpressure: RACK low stalls in WAIT; CPU_SLAVE_BERR_TIMEOUT_EN adds a TIMEOUT-cycle bus-error escape.
module cpu_slave_sm #(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic CLK,
    input  logic aRESET_,
    input  logic AS_,
    input  logic DS_,
    input  logic RW,
    input  logic SEL,
    input  logic RACK,
    output logic REG_RD,
    output logic REG_WR,
    output logic DOE,
    output logic DSACK0_,
    output logic DSACK1_,
    output logic DSACK_OE,
    output logic BERR_,
    output logic BUSY
);

    // Elaboration-time parameter range checks.
    if (WAIT_STATES > 15) begin : g_bad_wait_states
        $error("cpu_slave_sm: WAIT_STATES must be 0..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("cpu_slave_sm: TIMEOUT must be 1..255");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACCESS  = 3'd1,
        S_WAIT    = 3'd2,
        S_ACK     = 3'd3,
        S_RELEASE = 3'd4,
        S_BERR    = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic       as_meta_q, as_sync_q;
    logic       ds_meta_q, ds_sync_q;
    logic [1:0] fill_q;
    logic       arm_q, arm_d;
    logic       rw_q, rw_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic       reg_rd_d, reg_wr_d, doe_d, dsack_n_d, dsack_oe_d, busy_d;
`ifdef CPU_SLAVE_BERR_TIMEOUT_EN
    logic [7:0] tcnt_q, tcnt_d;
    logic       berr_n_q, berr_n_d;
`endif

    // Two-flop synchronisers for the asynchronous strobes; fill_q marks when sync output holds a real sample.
    always_ff @(posedge CLK or negedge aRESET_) begin
        if (!aRESET_) begin
            as_meta_q <= 1'b1;
            as_sync_q <= 1'b1;
            ds_meta_q <= 1'b1;
            ds_sync_q <= 1'b1;
            fill_q    <= 2'b00;
        end else begin
            as_meta_q <= AS_;
            as_sync_q <= as_meta_q;
            ds_meta_q <= DS_;
            ds_sync_q <= ds_meta_q;
            fill_q    <= {fill_q[0], 1'b1};
        end
    end

    // Next-state, counters and registered-output decode from the next state.
    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        // Re-arm only after a genuine (post-reset) sample of AS_ negated: one access per AS_ assertion.
        arm_d   = arm_q | (fill_q[1] & as_sync_q);
        wcnt_d  = wcnt_q;
`ifdef CPU_SLAVE_BERR_TIMEOUT_EN
        tcnt_d  = tcnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arm_q && !as_sync_q && !ds_sync_q && SEL) begin
                    state_d = S_ACCESS;
                    rw_d    = RW;
                    arm_d   = 1'b0;
                end
            end
            S_ACCESS: begin
                wcnt_d  = 4'(WAIT_STATES);
`ifdef CPU_SLAVE_BERR_TIMEOUT_EN
                tcnt_d  = 8'(TIMEOUT);
`endif
                state_d = as_sync_q ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (wcnt_q != 4'd0) wcnt_d = wcnt_q - 4'd1;
`ifdef CPU_SLAVE_BERR_TIMEOUT_EN
                if (tcnt_q != 8'd0) tcnt_d = tcnt_q - 8'd1;
`endif
                if (as_sync_q) begin
                    state_d = S_IDLE;
                end else if (wcnt_q == 4'd0 && RACK) begin
                    state_d = S_ACK;
`ifdef CPU_SLAVE_BERR_TIMEOUT_EN
                end else if (!RACK && tcnt_q <= 8'd1) begin
                    // Counter reaches zero on this edge with the register file still not ready.
                    state_d = S_BERR;
`endif
                end
            end
            S_ACK: begin
                if (as_sync_q) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
`ifdef CPU_SLAVE_BERR_TIMEOUT_EN
            S_BERR: begin
                if (as_sync_q) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        reg_rd_d   = (state_d == S_ACCESS) &&  rw_d;
        reg_wr_d   = (state_d == S_ACCESS) && !rw_d;
        dsack_n_d  = (state_d != S_ACK);
        dsack_oe_d = (state_d == S_ACK) || (state_d == S_RELEASE);
        doe_d      = (state_d == S_ACK) && rw_d;
        busy_d     = (state_d != S_IDLE);
`ifdef CPU_SLAVE_BERR_TIMEOUT_EN
        berr_n_d   = (state_d != S_BERR);
`endif
    end

    // State, capture and output registers.
    always_ff @(posedge CLK or negedge aRESET_) begin
        if (!aRESET_) begin
            state_q  <= S_IDLE;
            arm_q    <= 1'b0;
            rw_q     <= 1'b0;
            wcnt_q   <= 4'd0;
            REG_RD   <= 1'b0;
            REG_WR   <= 1'b0;
            DOE      <= 1'b0;
            DSACK0_  <= 1'b1;
            DSACK1_  <= 1'b1;
            DSACK_OE <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            state_q  <= state_d;
            arm_q    <= arm_d;
            rw_q     <= rw_d;
            wcnt_q   <= wcnt_d;
            REG_RD   <= reg_rd_d;
            REG_WR   <= reg_wr_d;
            DOE      <= doe_d;
            DSACK0_  <= dsack_n_d;
            DSACK1_  <= dsack_n_d;
            DSACK_OE <= dsack_oe_d;
            BUSY     <= busy_d;
        end
    end

`ifdef CPU_SLAVE_BERR_TIMEOUT_EN
    // Bus-error timeout counter and BERR_ output register.
    always_ff @(posedge CLK or negedge aRESET_) begin
        if (!aRESET_) begin
            tcnt_q   <= 8'd0;
            berr_n_q <= 1'b1;
        end else begin
            tcnt_q   <= tcnt_d;
            berr_n_q <= berr_n_d;
        end
    end
    assign BERR_ = berr_n_q;
`else
    assign BERR_ = 1'b1;
`endif

endmodule

// File: tb/tb_cpu_slave_sm.sv
// Directed bench for cpu_slave_sm: dut_a has WAIT_STATES=0, dut_b has WAIT_STATES=3 and TIMEOUT=8.
// Inputs are driven 1 time unit after each rising edge; outputs are checked at the same point.
// Both instances share the stimulus; each step checks the instance whose parameters it targets.
module tb_cpu_slave_sm;

    logic CLK, aRESET_, AS_, DS_, RW, SEL, RACK;
    logic a_REG_RD, a_REG_WR, a_DOE, a_DSACK0_, a_DSACK1_, a_DSACK_OE, a_BERR_, a_BUSY;
    logic b_REG_RD, b_REG_WR, b_DOE, b_DSACK0_, b_DSACK1_, b_DSACK_OE, b_BERR_, b_BUSY;

    int n_chk  = 0;
    int n_fail = 0;
    int a_rd_n = 0, a_wr_n = 0, b_wr_n = 0;
    int snap_rd, snap_wr;

    cpu_slave_sm #(.WAIT_STATES(0), .TIMEOUT(255)) dut_a (
        .CLK(CLK), .aRESET_(aRESET_), .AS_(AS_), .DS_(DS_), .RW(RW), .SEL(SEL), .RACK(RACK),
        .REG_RD(a_REG_RD), .REG_WR(a_REG_WR), .DOE(a_DOE), .DSACK0_(a_DSACK0_), .DSACK1_(a_DSACK1_),
        .DSACK_OE(a_DSACK_OE), .BERR_(a_BERR_), .BUSY(a_BUSY)
    );

    cpu_slave_sm #(.WAIT_STATES(3), .TIMEOUT(8)) dut_b (
        .CLK(CLK), .aRESET_(aRESET_), .AS_(AS_), .DS_(DS_), .RW(RW), .SEL(SEL), .RACK(RACK),
        .REG_RD(b_REG_RD), .REG_WR(b_REG_WR), .DOE(b_DOE), .DSACK0_(b_DSACK0_), .DSACK1_(b_DSACK1_),
        .DSACK_OE(b_DSACK_OE), .BERR_(b_BERR_), .BUSY(b_BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Strobe pulse counters, sampled mid-cycle.
    always @(negedge CLK) begin
        if (a_REG_RD) a_rd_n++;
        if (a_REG_WR) a_wr_n++;
        if (b_REG_WR) b_wr_n++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        aRESET_ = 1'b0; AS_ = 1'b1; DS_ = 1'b1; RW = 1'b1; SEL = 1'b0; RACK = 1'b0;
        #12;
        chk("rst_busy",  a_BUSY,     1'b0);
        chk("rst_oe",    a_DSACK_OE, 1'b0);
        chk("rst_dsack0", a_DSACK0_, 1'b1);
        chk("rst_dsack1", a_DSACK1_, 1'b1);
        chk("rst_doe",   a_DOE,      1'b0);
        chk("rst_rd",    a_REG_RD,   1'b0);
        chk("rst_wr",    a_REG_WR,   1'b0);
        chk("rst_berr",  a_BERR_,    1'b1);
        #10 aRESET_ = 1'b1;
        repeat (4) tick();

        // Read, zero wait states.
        SEL = 1'b1; RACK = 1'b1; RW = 1'b1; snap_rd = a_rd_n;
        AS_ = 1'b0; DS_ = 1'b0;
        tick(); chk("rd_e0_busy", a_BUSY, 1'b0);
        tick(); chk("rd_e1_rd", a_REG_RD, 1'b0);
        tick(); chk("rd_e2_rd", a_REG_RD, 1'b1); chk("rd_e2_busy", a_BUSY, 1'b1);
        tick(); chk("rd_e3_rd", a_REG_RD, 1'b0); chk("rd_e3_oe", a_DSACK_OE, 1'b0);
        tick();
        chk("rd_e4_dsack0", a_DSACK0_, 1'b0); chk("rd_e4_dsack1", a_DSACK1_, 1'b0);
        chk("rd_e4_doe", a_DOE, 1'b1);        chk("rd_e4_oe", a_DSACK_OE, 1'b1);
        AS_ = 1'b1; DS_ = 1'b1;
        tick(); chk("rd_e5_hold", a_DSACK0_, 1'b0);
        tick(); tick();
        chk("rd_rel_oe", a_DSACK_OE, 1'b1); chk("rd_rel_dsack0", a_DSACK0_, 1'b1);
        chk("rd_rel_dsack1", a_DSACK1_, 1'b1); chk("rd_rel_doe", a_DOE, 1'b0);
        tick(); chk("rd_idle_oe", a_DSACK_OE, 1'b0); chk("rd_idle_busy", a_BUSY, 1'b0);
        chk_n("rd_pulses", a_rd_n - snap_rd, 1);
        repeat (3) tick();

        // Write, three wait states (dut_b).
        RW = 1'b0; RACK = 1'b1; snap_wr = b_wr_n;
        AS_ = 1'b0; DS_ = 1'b0;
        tick(); tick();
        tick(); chk("wr_e2_wr", b_REG_WR, 1'b1);
        tick(); chk("wr_e3_wr", b_REG_WR, 1'b0); chk("wr_e3_doe", b_DOE, 1'b0);
        tick(); tick(); tick(); chk("wr_e6_dsack0", b_DSACK0_, 1'b1);
        tick();
        chk("wr_e7_dsack0", b_DSACK0_, 1'b0); chk("wr_e7_dsack1", b_DSACK1_, 1'b0);
        chk("wr_e7_doe", b_DOE, 1'b0);        chk("wr_e7_oe", b_DSACK_OE, 1'b1);
        AS_ = 1'b1; DS_ = 1'b1;
        repeat (4) tick();
        chk("wr_idle_oe", b_DSACK_OE, 1'b0); chk("wr_idle_busy", b_BUSY, 1'b0);
        chk_n("wr_pulses", b_wr_n - snap_wr, 1);
        repeat (3) tick();

        // RACK held low for 20 cycles in WAIT (dut_a).
        RW = 1'b1; RACK = 1'b0; snap_rd = a_rd_n;
        AS_ = 1'b0; DS_ = 1'b0;
        repeat (5) tick();
        repeat (20) tick();
        chk("rack_wait_dsack", a_DSACK0_, 1'b1); chk("rack_wait_busy", a_BUSY, 1'b1);
        RACK = 1'b1;
        tick(); chk("rack_ack_dsack", a_DSACK0_, 1'b0);
        chk_n("rack_rd_pulses", a_rd_n - snap_rd, 1);
        AS_ = 1'b1; DS_ = 1'b1;
        repeat (5) tick(); chk("rack_idle_busy", a_BUSY, 1'b0);

        // SEL low: strobes must be ignored.
        SEL = 1'b0; RACK = 1'b1; snap_rd = a_rd_n; snap_wr = a_wr_n;
        AS_ = 1'b0; DS_ = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("nosel_busy", a_BUSY, 1'b0);
            chk("nosel_oe", a_DSACK_OE, 1'b0);
        end
        chk_n("nosel_rd", a_rd_n - snap_rd, 0);
        chk_n("nosel_wr", a_wr_n - snap_wr, 0);
        AS_ = 1'b1; DS_ = 1'b1; SEL = 1'b1;
        repeat (3) tick();

        // Abort in WAIT, then a normal access.
        RACK = 1'b0; RW = 1'b1;
        AS_ = 1'b0; DS_ = 1'b0;
        repeat (5) tick(); chk("abort_wait_busy", a_BUSY, 1'b1);
        AS_ = 1'b1; DS_ = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_dsack", a_DSACK_OE, 1'b0);
        end
        chk("abort_idle_busy", a_BUSY, 1'b0);
        repeat (2) tick();
        RACK = 1'b1;
        AS_ = 1'b0; DS_ = 1'b0;
        repeat (5) tick(); chk("after_abort_ack", a_DSACK0_, 1'b0);
        AS_ = 1'b1; DS_ = 1'b1;
        repeat (5) tick();

`ifdef CPU_SLAVE_BERR_TIMEOUT_EN
        // Bus-error timeout on dut_b (TIMEOUT=8, WAIT entered at e3).
        RACK = 1'b0;
        AS_ = 1'b0; DS_ = 1'b0;
        repeat (11) tick(); chk("to_e10_berr", b_BERR_, 1'b1);
        tick(); chk("to_e11_berr", b_BERR_, 1'b0); chk("to_e11_oe", b_DSACK_OE, 1'b0);
        repeat (5) tick(); chk("to_hold_berr", b_BERR_, 1'b0);
        AS_ = 1'b1; DS_ = 1'b1;
        repeat (3) tick(); chk("to_idle_berr", b_BERR_, 1'b1); chk("to_idle_busy", b_BUSY, 1'b0);
        repeat (3) tick();
`endif

        // Asynchronous reset in the middle of ACK.
        RACK = 1'b1; RW = 1'b1;
        AS_ = 1'b0; DS_ = 1'b0;
        repeat (5) tick(); chk("mid_ack_dsack", a_DSACK0_, 1'b0);
        #2 aRESET_ = 1'b0;
        #1;
        chk("arst_dsack0", a_DSACK0_, 1'b1); chk("arst_dsack1", a_DSACK1_, 1'b1);
        chk("arst_oe", a_DSACK_OE, 1'b0);    chk("arst_doe", a_DOE, 1'b0);
        chk("arst_busy", a_BUSY, 1'b0);      chk("arst_berr", a_BERR_, 1'b1);
        #1 aRESET_ = 1'b1;
        repeat (8) tick(); chk("arst_no_restart", a_BUSY, 1'b0);
        AS_ = 1'b1; DS_ = 1'b1;
        repeat (3) tick();
        AS_ = 1'b0; DS_ = 1'b0;
        repeat (5) tick(); chk("arst_fresh_ack", a_DSACK0_, 1'b0);
        AS_ = 1'b1; DS_ = 1'b1;
        repeat (5) tick(); chk("arst_final_idle", a_BUSY, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_slave_sm.md
CPU_SLAVE_SM -- requirements
Module: cpu_slave_sm

Interface
REQ-001 Parameter WAIT_STATES, default 0, extra CLK cycles inserted before acknowledge (0..15).
REQ-002 Parameter TIMEOUT, default 255, CLK cycles in WAIT before bus error (1..255, used only under macro).
REQ-003 CLK  in  1  CPU clock; all state updates on rising edge.
REQ-004 aRESET_  in  1  asynchronous active-low reset.
REQ-005 AS_  in  1  68030 address strobe, asynchronous, active low.
REQ-006 DS_  in  1  68030 data strobe, asynchronous, active low.
REQ-007 RW  in  1  1 = CPU read, 0 = CPU write; sampled with strobes.
REQ-008 SEL  in  1  register-space address decode hit, stable while AS_ low.
REQ-009 RACK  in  1  register file ready; level, held until strobe cycle ends.
REQ-010 REG_RD  out  1  one-cycle read strobe to register file.
REQ-011 REG_WR  out  1  one-cycle write strobe to register file.
REQ-012 DOE  out  1  data bus output enable, reads only.
REQ-013 DSACK0_, DSACK1_  out  1 each  data transfer acknowledge, both low = 32-bit port.
REQ-014 DSACK_OE  out  1  tri-state enable for DSACK0_/DSACK1_.
REQ-015 BERR_  out  1  bus error, active low.
REQ-016 BUSY  out  1  high whenever state is not IDLE.

Function
REQ-017 AS_ and DS_ SHALL each pass a 2-flop synchroniser on CLK; the FSM uses only synchronised copies.
REQ-018 States SHALL be IDLE, ACCESS, WAIT, ACK, RELEASE (plus BERR under macro); all outputs registered, decoded from state.
REQ-019 IDLE->ACCESS when synced AS_ low, synced DS_ low, SEL high; RW captured on this edge.
REQ-020 ACCESS SHALL last exactly one cycle, assert REG_RD (RW=1) or REG_WR (RW=0), then go to WAIT.
REQ-021 On WAIT entry a 4-bit counter SHALL load WAIT_STATES and decrement each cycle to 0, no wrap.
REQ-022 WAIT->ACK when counter = 0 and RACK high; RACK high earlier does not shorten the wait.
REQ-023 In ACK: DSACK0_=DSACK1_=0, DSACK_OE=1, DOE=captured RW; hold until synced AS_ high, then go to RELEASE.
REQ-024 RELEASE SHALL drive DSACK0_/DSACK1_ high with DSACK_OE=1 for exactly one cycle (active negation), DOE=0, then go to IDLE.
REQ-025 Synced AS_ high in ACCESS or WAIT SHALL abort to IDLE with no DSACK; an already-issued REG_WR is not retracted.
REQ-026 Back-to-back cycles: a new cycle SHALL NOT start before IDLE is re-entered; at most one REG_RD/REG_WR per AS_ assertion.
REQ-027 Latency: raw strobes first sampled low at edge e0 -> REG_* high after e2 -> DSACK low after edge e4+WAIT_STATES (RACK high).

Reset
REQ-028 aRESET_ low SHALL immediately force IDLE, sync flops to 1, DSACK0_=DSACK1_=1, DSACK_OE=0, DOE=0, REG_RD=REG_WR=0, BERR_=1, BUSY=0, counters to 0.
REQ-029 Reset mid-cycle SHALL abandon the cycle; after release the FSM waits in IDLE for a fresh strobe assertion (synced AS_ must be seen high first).

Configuration
REQ-030 Macro CPU_SLAVE_BERR_TIMEOUT_EN defined: an 8-bit counter loads TIMEOUT on WAIT entry; reaching 0 with RACK low moves to BERR, driving BERR_=0, no DSACK, until synced AS_ high, then IDLE.
REQ-031 Macro undefined: WAIT holds indefinitely for RACK; BERR_ constant 1; no timeout counter synthesised.

Verification
REQ-032 Read, WAIT_STATES=0, RACK=1: AS_/DS_ low at e0 -> REG_RD one cycle after e2, DSACK0_/1_=0 and DOE=1 after e4; AS_ high -> one cycle DSACK high with OE=1, then OE=0.
REQ-033 Write, WAIT_STATES=3, RACK=1: REG_WR single pulse, DOE stays 0, DSACK low after e7.
REQ-034 RACK held low 20 cycles then high, WAIT_STATES=0: DSACK low on edge after RACK sampled high; exactly one REG_RD.
REQ-035 SEL=0 with strobes low 10 cycles: no REG_* pulse, DSACK_OE=0, BUSY=0 throughout.
REQ-036 AS_ negated during WAIT (RACK=0): return to IDLE, no DSACK, next cycle acknowledged normally.
REQ-037 Macro on, TIMEOUT=8, RACK=0: BERR_=0 8 cycles after WAIT entry, held until AS_ high; aRESET_ pulse mid-ACK -> all outputs at reset values immediately.
